// File: rtl/lab2_proc_hazard_ctrl_if.sv
// Control bundle between the TinyRV2 datapath and the hazard/sequencing controller.
// The master side is the datapath (or a bench); the slave side is the controller.
interface lab2_proc_hazard_ctrl_if;
    logic        val_D;
    logic        rs1_en_D;
    logic        rs2_en_D;
    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic [4:0]  rd_D;
    logic        wen_D;
    logic        is_load_D;
    logic        is_imul_D;
    logic        squash_D;
    logic        stall_M_in;
    logic        stall_W_in;
    logic        imul_req_rdy_D;
    logic        imul_resp_val_X;

    logic        imul_req_val_D;
    logic        imul_resp_rdy_X;
    logic [1:0]  op1_byp_sel_D;
    logic [1:0]  op2_byp_sel_D;
    logic        reg_en_D;
    logic        reg_en_X;
    logic        reg_en_M;
    logic        reg_en_W;
    logic        val_X;
    logic        val_M;
    logic        val_W;
    logic        rf_wen_W;
    logic [4:0]  rf_waddr_W;
    logic [31:0] num_retired;

    modport master (
        output val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rd_D, wen_D,
               is_load_D, is_imul_D, squash_D, stall_M_in, stall_W_in,
               imul_req_rdy_D, imul_resp_val_X,
        input  imul_req_val_D, imul_resp_rdy_X, op1_byp_sel_D, op2_byp_sel_D,
               reg_en_D, reg_en_X, reg_en_M, reg_en_W, val_X, val_M, val_W,
               rf_wen_W, rf_waddr_W, num_retired
    );

    modport slave (
        input  val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rd_D, wen_D,
               is_load_D, is_imul_D, squash_D, stall_M_in, stall_W_in,
               imul_req_rdy_D, imul_resp_val_X,
        output imul_req_val_D, imul_resp_rdy_X, op1_byp_sel_D, op2_byp_sel_D,
               reg_en_D, reg_en_X, reg_en_M, reg_en_W, val_X, val_M, val_W,
               rf_wen_W, rf_waddr_W, num_retired
    );
endinterface

// File: rtl/lab2_proc_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage TinyRV2 pipeline with an iterative
// multiplier: tracks X/M/W metadata and drives bypass selects, stalls, bubbles and RF writes.
module lab2_proc_hazard_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    lab2_proc_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
        logic       is_imul;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t      stage_x_q, stage_x_d;
    stage_t      stage_m_q, stage_m_d;
    stage_t      stage_w_q, stage_w_d;
    stage_t      stage_dec;
    logic [31:0] num_retired_q, num_retired_d;

    logic src1_x, src2_x;
    logic hazard_d;
    logic stall_w, stall_m, stall_x, stall_d;

    function automatic logic src_match(input stage_t s, input logic en, input logic [4:0] rs);
        return s.val && s.wen && (s.rd == rs) && (rs != 5'd0) && en;
    endfunction

    // Youngest producer wins, so X is checked before M before W.
    function automatic logic [1:0] byp_sel(input stage_t x, input stage_t m, input stage_t w,
                                           input logic en, input logic [4:0] rs);
        if (src_match(x, en, rs))      return 2'd1;
        else if (src_match(m, en, rs)) return 2'd2;
        else if (src_match(w, en, rs)) return 2'd3;
        else                           return 2'd0;
    endfunction

    always_comb begin
        src1_x   = src_match(stage_x_q, bus.rs1_en_D, bus.rs1_D);
        src2_x   = src_match(stage_x_q, bus.rs2_en_D, bus.rs2_D);
        hazard_d = bus.val_D && (src1_x || src2_x) &&
                   (stage_x_q.is_load || (stage_x_q.is_imul && !bus.imul_resp_val_X));

        stall_w = stage_w_q.val && bus.stall_W_in;
        stall_m = (stage_m_q.val && bus.stall_M_in) || stall_w;
        stall_x = (stage_x_q.val && stage_x_q.is_imul && !bus.imul_resp_val_X) || stall_m;
        stall_d = (bus.val_D && (hazard_d || (bus.is_imul_D && !bus.imul_req_rdy_D))) || stall_x;
    end

    assign stage_dec = '{val:     bus.val_D,
                         rd:      bus.rd_D,
                         wen:     bus.wen_D,
                         is_load: bus.is_load_D,
                         is_imul: bus.is_imul_D};

    always_comb begin
        // NOTE: every stage defaults to hold so no path through this block can infer a latch.
        stage_x_d     = stage_x_q;
        stage_m_d     = stage_m_q;
        stage_w_d     = stage_w_q;
        num_retired_d = num_retired_q;

        if (!stall_w) stage_w_d = stall_m ? BUBBLE : stage_m_q;
        if (!stall_m) stage_m_d = stall_x ? BUBBLE : stage_x_q;
        // A squashed D instruction only dies when X is free to take the bubble.
        if (!stall_x) stage_x_d = (stall_d || bus.squash_D) ? BUBBLE : stage_dec;

        if (stage_w_q.val && !bus.stall_W_in) num_retired_d = num_retired_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_x_q     <= BUBBLE;
            stage_m_q     <= BUBBLE;
            stage_w_q     <= BUBBLE;
            num_retired_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge values of the older stages.
            stage_x_q     <= stage_x_d;
            stage_m_q     <= stage_m_d;
            stage_w_q     <= stage_w_d;
            num_retired_q <= num_retired_d;
        end
    end

    assign bus.op1_byp_sel_D   = byp_sel(stage_x_q, stage_m_q, stage_w_q, bus.rs1_en_D, bus.rs1_D);
    assign bus.op2_byp_sel_D   = byp_sel(stage_x_q, stage_m_q, stage_w_q, bus.rs2_en_D, bus.rs2_D);
    assign bus.reg_en_D        = !stall_d;
    assign bus.reg_en_X        = !stall_x;
    assign bus.reg_en_M        = !stall_m;
    assign bus.reg_en_W        = !stall_w;
    assign bus.imul_req_val_D  = bus.val_D && bus.is_imul_D && !hazard_d && !stall_x && !bus.squash_D;
    assign bus.imul_resp_rdy_X = stage_x_q.val && stage_x_q.is_imul && !stall_m;
    assign bus.val_X           = stage_x_q.val;
    assign bus.val_M           = stage_m_q.val;
    assign bus.val_W           = stage_w_q.val;
    assign bus.rf_wen_W        = stage_w_q.val && stage_w_q.wen;
    assign bus.rf_waddr_W      = stage_w_q.rd;
    assign bus.num_retired     = num_retired_q;

endmodule

// File: tb/tb_lab2_proc_hazard_ctrl.sv
// Directed bench for lab2_proc_hazard_ctrl: the driver queues hand-computed per-cycle
// expectations and a monitor pops and compares them on the falling edge.
module tb_lab2_proc_hazard_ctrl;
    typedef struct packed {
        logic [1:0]  byp1;
        logic [1:0]  byp2;
        logic [3:0]  reg_en;   // D,X,M,W
        logic [2:0]  val;      // X,M,W
        logic        req_val;
        logic        resp_rdy;
        logic        rf_wen;
        logic [4:0]  waddr;
        logic [31:0] retired;
    } exp_t;

    logic clk;
    logic reset;
    lab2_proc_hazard_ctrl_if bus ();

    lab2_proc_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  sb[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    idle   = 0;
    logic  stim_done = 1'b0;

    localparam logic [3:0] ALL_EN = 4'b1111;

    function automatic exp_t mk(input logic [1:0] byp1, input logic [1:0] byp2,
                                input logic [3:0] reg_en, input logic [2:0] val,
                                input logic req_val, input logic resp_rdy, input logic rf_wen,
                                input logic [4:0] waddr, input logic [31:0] retired);
        exp_t e;
        e = '{byp1:byp1, byp2:byp2, reg_en:reg_en, val:val, req_val:req_val,
              resp_rdy:resp_rdy, rf_wen:rf_wen, waddr:waddr, retired:retired};
        return e;
    endfunction

    task automatic d_instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic en1, input logic en2, input logic wen,
                           input logic ld, input logic im);
        bus.val_D     = 1'b1;
        bus.rd_D      = rd;
        bus.rs1_D     = rs1;
        bus.rs2_D     = rs2;
        bus.rs1_en_D  = en1;
        bus.rs2_en_D  = en2;
        bus.wen_D     = wen;
        bus.is_load_D = ld;
        bus.is_imul_D = im;
    endtask

    task automatic d_nop();
        d_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.val_D = 1'b0;
    endtask

    // Inputs are already applied; queue the expectation and move to just after the next edge.
    task automatic step(input string name, input exp_t e);
        sb.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t  exp_v;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                idle  = 0;
                exp_v = sb.pop_front();
                nm    = name_q.pop_front();
                act   = mk(bus.op1_byp_sel_D, bus.op2_byp_sel_D,
                           {bus.reg_en_D, bus.reg_en_X, bus.reg_en_M, bus.reg_en_W},
                           {bus.val_X, bus.val_M, bus.val_W},
                           bus.imul_req_val_D, bus.imul_resp_rdy_X, bus.rf_wen_W,
                           bus.rf_waddr_W, bus.num_retired);
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got byp=%0d/%0d en=%b val=%b req=%b rdy=%b wen=%b wa=%0d ret=%0d; want byp=%0d/%0d en=%b val=%b req=%b rdy=%b wen=%b wa=%0d ret=%0d",
                             nm, act.byp1, act.byp2, act.reg_en, act.val, act.req_val, act.resp_rdy,
                             act.rf_wen, act.waddr, act.retired,
                             exp_v.byp1, exp_v.byp2, exp_v.reg_en, exp_v.val, exp_v.req_val,
                             exp_v.resp_rdy, exp_v.rf_wen, exp_v.waddr, exp_v.retired);
                end
            end else if (stim_done) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else begin
                idle++;
                if (idle > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL watchdog: got no expectation for %0d cycles, want at most 50", idle);
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        d_nop();
        bus.squash_D        = 1'b0;
        bus.stall_M_in      = 1'b0;
        bus.stall_W_in      = 1'b0;
        bus.imul_req_rdy_D  = 1'b0;
        bus.imul_resp_val_X = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step("all_low", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 0));
        bus.imul_req_rdy_D = 1'b1;

        // RAW chain: add x1 / add x2,x1,x1 / add x3,x1,x2
        d_instr(1, 0, 0, 1, 1, 1, 0, 0); step("raw_c1", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 0));
        d_instr(2, 1, 1, 1, 1, 1, 0, 0); step("raw_c2", mk(1, 1, ALL_EN, 3'b100, 0, 0, 0, 0, 0));
        d_instr(3, 1, 2, 1, 1, 1, 0, 0); step("raw_c3", mk(2, 1, ALL_EN, 3'b110, 0, 0, 0, 0, 0));
        d_nop();                         step("raw_c4", mk(0, 0, ALL_EN, 3'b111, 0, 0, 1, 1, 0));
        step("raw_c5", mk(0, 0, ALL_EN, 3'b011, 0, 0, 1, 2, 1));
        step("raw_c6", mk(0, 0, ALL_EN, 3'b001, 0, 0, 1, 3, 2));

        // Load-use: lw x5 / add x6,x5,x0
        d_instr(5, 0, 0, 1, 0, 1, 1, 0); step("lu_c1",    mk(0, 0, ALL_EN,  3'b000, 0, 0, 0, 0, 3));
        d_instr(6, 5, 0, 1, 1, 1, 0, 0); step("lu_stall", mk(1, 0, 4'b0111, 3'b100, 0, 0, 0, 0, 3));
        step("lu_byp_m", mk(2, 0, ALL_EN, 3'b010, 0, 0, 0, 0, 3));
        d_nop();
        step("lu_c4", mk(0, 0, ALL_EN, 3'b101, 0, 0, 1, 5, 3));
        step("lu_c5", mk(0, 0, ALL_EN, 3'b010, 0, 0, 0, 0, 4));
        step("lu_c6", mk(0, 0, ALL_EN, 3'b001, 0, 0, 1, 6, 4));

        // Imul: mul x7,x1,x2 with a 4-cycle response delay, then add x8,x7,x0
        d_instr(7, 1, 2, 1, 1, 1, 0, 1); step("mul_req", mk(0, 0, ALL_EN, 3'b000, 1, 0, 0, 0, 5));
        d_instr(8, 7, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("mul_wait%0d", i), mk(1, 0, 4'b0011, 3'b100, 0, 1, 0, 0, 5));
        bus.imul_resp_val_X = 1'b1;
        step("mul_resp", mk(1, 0, ALL_EN, 3'b100, 0, 1, 0, 0, 5));
        bus.imul_resp_val_X = 1'b0;
        d_nop();
        step("mul_c7", mk(0, 0, ALL_EN, 3'b110, 0, 0, 0, 0, 5));
        step("mul_c8", mk(0, 0, ALL_EN, 3'b011, 0, 0, 1, 7, 5));
        step("mul_c9", mk(0, 0, ALL_EN, 3'b001, 0, 0, 1, 8, 6));

        // Back-pressure from M for 3 cycles
        d_instr(9,  0, 0, 0, 0, 1, 0, 0); step("bp_c1", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 7));
        d_instr(10, 0, 0, 0, 0, 1, 0, 0); step("bp_c2", mk(0, 0, ALL_EN, 3'b100, 0, 0, 0, 0, 7));
        d_instr(11, 0, 0, 0, 0, 1, 0, 0); step("bp_c3", mk(0, 0, ALL_EN, 3'b110, 0, 0, 0, 0, 7));
        d_nop();
        bus.stall_M_in = 1'b1;
        step("bp_s0", mk(0, 0, 4'b0001, 3'b111, 0, 0, 1, 9, 7));
        step("bp_s1", mk(0, 0, 4'b0001, 3'b110, 0, 0, 0, 0, 8));
        step("bp_s2", mk(0, 0, 4'b0001, 3'b110, 0, 0, 0, 0, 8));
        bus.stall_M_in = 1'b0;
        step("bp_rel", mk(0, 0, ALL_EN, 3'b110, 0, 0, 0, 0, 8));
        step("bp_c8",  mk(0, 0, ALL_EN, 3'b011, 0, 0, 1, 10, 8));
        step("bp_c9",  mk(0, 0, ALL_EN, 3'b001, 0, 0, 1, 11, 9));

        // Squash under stall: branch in X, mul x14 in D, M held for 2 cycles
        d_instr(13, 0, 0, 0, 0, 1, 0, 0); step("sq_c1", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 10));
        d_instr(0,  0, 0, 0, 0, 0, 0, 0); step("sq_c2", mk(0, 0, ALL_EN, 3'b100, 0, 0, 0, 0, 10));
        d_instr(14, 0, 0, 0, 0, 1, 0, 1);
        bus.squash_D   = 1'b1;
        bus.stall_M_in = 1'b1;
        step("sq_stall0", mk(0, 0, 4'b0001, 3'b110, 0, 0, 0, 0, 10));
        step("sq_stall1", mk(0, 0, 4'b0001, 3'b110, 0, 0, 0, 0, 10));
        bus.stall_M_in = 1'b0;
        step("sq_rel", mk(0, 0, ALL_EN, 3'b110, 0, 0, 0, 0, 10));
        bus.squash_D = 1'b0;
        d_nop();
        step("sq_c6", mk(0, 0, ALL_EN, 3'b011, 0, 0, 1, 13, 10));
        step("sq_c7", mk(0, 0, ALL_EN, 3'b001, 0, 0, 0, 0, 11));

        // Multiplier not ready: D stalls while the request is still offered
        d_instr(15, 0, 0, 0, 0, 1, 0, 1);
        bus.imul_req_rdy_D = 1'b0;
        step("mul_nrdy", mk(0, 0, 4'b0111, 3'b000, 1, 0, 0, 0, 12));
        bus.imul_req_rdy_D = 1'b1;

        // Fill X/M/W, then reset asynchronously mid-stream
        d_instr(1, 0, 0, 0, 0, 1, 0, 0); step("rst_c1", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 12));
        d_instr(2, 0, 0, 0, 0, 1, 0, 0); step("rst_c2", mk(0, 0, ALL_EN, 3'b100, 0, 0, 0, 0, 12));
        d_instr(3, 0, 0, 0, 0, 1, 0, 0); step("rst_c3", mk(0, 0, ALL_EN, 3'b110, 0, 0, 0, 0, 12));
        d_instr(4, 0, 0, 0, 0, 1, 0, 0); step("rst_c4", mk(0, 0, ALL_EN, 3'b111, 0, 0, 1, 1, 12));
        d_nop();
        reset = 1'b1;
        step("rst_async", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step("rst_after", mk(0, 0, ALL_EN, 3'b000, 0, 0, 0, 0, 0));

        stim_done = 1'b1;
    end
endmodule
